// File: rtl/training_sequencer.sv
// training_sequencer: steps a Perceptron through train/eval epochs and a final test pass,
// scoring each presented sample against its stored label one cycle later.
module training_sequencer #(
    parameter int  input_units = 2,
    parameter int  num_samples = 4,
    parameter int  num_epochs  = 10,
    parameter real threshold   = 0.5,
    localparam int IW = (num_samples > 1) ? $clog2(num_samples) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_index,
    input  real           wr_values [input_units],
    input  real           wr_expected,
    input  logic          start,
    input  real           prediction,
    output real           values [input_units],
    output real           expected,
    output logic          training,
    output logic          busy,
    output logic          done,
    output int            epoch,
    output int            epoch_correct,
    output logic          epoch_correct_valid,
    output int            test_correct
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRAIN, S_EVAL, S_TEST, S_FLUSH, S_DONE
    } state_t;

    state_t        r_state, w_next_state;
    logic [IW-1:0] r_idx, w_next_idx;
    int            r_epoch, w_next_epoch;

    real  r_table [num_samples][input_units];
    real  r_exp_table [num_samples];
    real  r_values [input_units];
    real  r_expected;
    logic r_training;

    logic r_pend, r_pend_test, r_pend_last;
    real  r_pend_exp;
    int   r_eval_cnt, r_epoch_correct, r_test_correct;

    logic w_last, w_wr, w_present, w_correct;
    int   w_eval_final;

    assign w_last    = (int'(r_idx) == num_samples - 1);
    assign w_wr      = wr_en && (r_state == S_IDLE);
    assign w_present = (w_next_state == S_TRAIN) || (w_next_state == S_EVAL) ||
                       (w_next_state == S_TEST);

    // Table has no reset so loaded samples survive a run abort.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_table[wr_index]     <= wr_values;
            r_exp_table[wr_index] <= wr_expected;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_epoch <= 0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_epoch <= w_next_epoch;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_epoch = r_epoch;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_TRAIN;
                    w_next_idx   = '0;
                    w_next_epoch = 0;
                end
            end
            S_TRAIN: begin
                if (w_last) begin
                    w_next_state = S_EVAL;
                    w_next_idx   = '0;
                end else begin
                    w_next_idx = r_idx + IW'(1);
                end
            end
            S_EVAL: begin
                if (w_last) begin
                    w_next_idx = '0;
                    if (r_epoch == num_epochs - 1) begin
                        w_next_state = S_TEST;
                    end else begin
                        w_next_state = S_TRAIN;
                        w_next_epoch = r_epoch + 1;
                    end
                end else begin
                    w_next_idx = r_idx + IW'(1);
                end
            end
            S_TEST: begin
                if (w_last) begin
                    w_next_state = S_FLUSH;
                    w_next_idx   = '0;
                end else begin
                    w_next_idx = r_idx + IW'(1);
                end
            end
            S_FLUSH: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // A write in the start cycle is forwarded so the first presentation sees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < input_units; i++) r_values[i] <= 0.0;
            r_expected <= 0.0;
            r_training <= 1'b0;
        end else begin
            r_training <= (w_next_state == S_TRAIN);
            if (w_present) begin
                if (w_wr && (wr_index == w_next_idx)) begin
                    r_values   <= wr_values;
                    r_expected <= wr_expected;
                end else begin
                    r_values   <= r_table[w_next_idx];
                    r_expected <= r_exp_table[w_next_idx];
                end
            end
        end
    end

    assign w_correct    = (prediction < threshold) == (r_pend_exp < threshold);
    assign w_eval_final = r_eval_cnt +
                          ((r_pend && !r_pend_test && w_correct) ? 1 : 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend          <= 1'b0;
            r_pend_test     <= 1'b0;
            r_pend_last     <= 1'b0;
            r_pend_exp      <= 0.0;
            r_eval_cnt      <= 0;
            r_epoch_correct <= 0;
            r_test_correct  <= 0;
        end else begin
            r_pend      <= (r_state == S_EVAL) || (r_state == S_TEST);
            r_pend_test <= (r_state == S_TEST);
            r_pend_last <= (r_state == S_EVAL) && w_last;
            r_pend_exp  <= r_expected;
            if (r_pend_last) begin
                r_epoch_correct <= w_eval_final;
                r_eval_cnt      <= 0;
            end else begin
                r_eval_cnt <= w_eval_final;
            end
            if ((r_state == S_IDLE) && start) begin
                r_test_correct <= 0;
            end else if (r_pend && r_pend_test && w_correct) begin
                r_test_correct <= r_test_correct + 1;
            end
        end
    end

    // The final epoch count is shown in the same cycle its last sample is scored.
    always_comb begin
        busy                = (r_state != S_IDLE) && (r_state != S_DONE);
        done                = (r_state == S_DONE);
        epoch_correct_valid = r_pend_last;
        epoch_correct       = r_pend_last ? w_eval_final : r_epoch_correct;
    end

    assign values       = r_values;
    assign expected     = r_expected;
    assign training     = r_training;
    assign epoch        = r_epoch;
    assign test_correct = r_test_correct;

endmodule

// File: tb/tb_training_sequencer.sv
// Bench for training_sequencer: perceptron oracle, presentation-queue model,
// randomized tables, mid-run disturbances and async reset abort.
module tb_training_sequencer;

    logic clk;
    logic rst;

    logic       wr_en;
    logic [1:0] wr_index;
    real        wr_values [2];
    real        wr_expected;
    logic       start;
    real        prediction;
    real        values [2];
    real        expected;
    logic       training, busy, done, ec_valid;
    int         epoch, epoch_correct, test_correct;

    logic       s_wr_en;
    logic [0:0] s_wr_index;
    real        s_wr_values [2];
    real        s_wr_expected;
    logic       s_start;
    real        s_pred;
    real        s_values [2];
    real        s_expected;
    logic       s_training, s_busy, s_done, s_ec_valid;
    int         s_epoch, s_epoch_correct, s_test_correct;

    int  total = 0;
    int  bad   = 0;
    int  mode  = 0;
    real m_val [4][2];
    real m_lab [4];

    typedef struct {
        int s;
        int pass;
        int ep;
    } pres_t;

    training_sequencer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_index(wr_index),
        .wr_values(wr_values), .wr_expected(wr_expected), .start(start),
        .prediction(prediction), .values(values), .expected(expected),
        .training(training), .busy(busy), .done(done), .epoch(epoch),
        .epoch_correct(epoch_correct), .epoch_correct_valid(ec_valid),
        .test_correct(test_correct)
    );

    training_sequencer #(.num_samples(1), .num_epochs(1)) dut_s (
        .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_index(s_wr_index),
        .wr_values(s_wr_values), .wr_expected(s_wr_expected), .start(s_start),
        .prediction(s_pred), .values(s_values), .expected(s_expected),
        .training(s_training), .busy(s_busy), .done(s_done), .epoch(s_epoch),
        .epoch_correct(s_epoch_correct), .epoch_correct_valid(s_ec_valid),
        .test_correct(s_test_correct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real orc(input real a, input real b, input int md);
        bit y;
        y = (a >= 0.5) && (b >= 0.5);
        case (md)
            0:       return y ? 1.0 : 0.0;
            1:       return y ? 0.0 : 1.0;
            default: return 0.49;
        endcase
    endfunction

    // Perceptron stand-ins: prediction registered from the presented sample.
    always @(posedge clk or posedge rst) begin
        if (rst) prediction <= 0.0;
        else     prediction <= orc(values[0], values[1], mode);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) s_pred <= 0.0;
        else     s_pred <= orc(s_values[0], s_values[1], 0);
    end

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        total++;
        assert ($realtobits(obs) === $realtobits(exp)) else begin
            bad++;
            $error("FAIL %s: got %f want %f", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk_r({pfx, "_v0"}, values[0], 0.0);
        chk_r({pfx, "_v1"}, values[1], 0.0);
        chk_r({pfx, "_exp"}, expected, 0.0);
        chk_b({pfx, "_train"}, training, 1'b0);
        chk_b({pfx, "_busy"}, busy, 1'b0);
        chk_b({pfx, "_done"}, done, 1'b0);
        chk_b({pfx, "_ecv"}, ec_valid, 1'b0);
        chk_i({pfx, "_epoch"}, epoch, 0);
        chk_i({pfx, "_ec"}, epoch_correct, 0);
        chk_i({pfx, "_tc"}, test_correct, 0);
    endtask

    task automatic load(input int idx, input real a, input real b, input real l);
        @(negedge clk);
        wr_en = 1'b1;
        wr_index = idx[1:0];
        wr_values[0] = a;
        wr_values[1] = b;
        wr_expected = l;
        @(negedge clk);
        wr_en = 1'b0;
        m_val[idx][0] = a;
        m_val[idx][1] = b;
        m_lab[idx] = l;
    endtask

    // Optional write issued in the same cycle as start.
    bit  ws_en = 1'b0;
    int  ws_idx;
    real ws_a, ws_b, ws_l;

    task automatic do_run(input int md, input bit disturb, input int abort_at);
        pres_t q[$];
        int    ec;
        int    n;
        bit    vexp;
        @(negedge clk);
        mode = md;
        start = 1'b1;
        if (ws_en) begin
            wr_en = 1'b1;
            wr_index = ws_idx[1:0];
            wr_values[0] = ws_a;
            wr_values[1] = ws_b;
            wr_expected = ws_l;
            m_val[ws_idx][0] = ws_a;
            m_val[ws_idx][1] = ws_b;
            m_lab[ws_idx] = ws_l;
        end
        ec = 0;
        for (int s = 0; s < 4; s++)
            if ((orc(m_val[s][0], m_val[s][1], md) < 0.5) == (m_lab[s] < 0.5)) ec++;
        for (int e = 0; e < 10; e++)
            for (int p = 0; p < 2; p++)
                for (int s = 0; s < 4; s++) q.push_back('{s, p, e});
        for (int s = 0; s < 4; s++) q.push_back('{s, 2, 9});
        n = q.size();
        @(posedge clk);
        for (int c = 0; c <= n + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (c == 0) chk_i("tc_cleared", test_correct, 0);
            if (c < n) begin
                chk_r("v0", values[0], m_val[q[c].s][0]);
                chk_r("v1", values[1], m_val[q[c].s][1]);
                chk_r("exp", expected, m_lab[q[c].s]);
                chk_b("training", training, q[c].pass == 0);
                chk_i("epoch", epoch, q[c].ep);
                chk_b("busy", busy, 1'b1);
                chk_b("done", done, 1'b0);
            end else if (c == n) begin
                chk_r("flush_v0", values[0], m_val[q[n-1].s][0]);
                chk_r("flush_v1", values[1], m_val[q[n-1].s][1]);
                chk_b("flush_train", training, 1'b0);
                chk_b("flush_busy", busy, 1'b1);
                chk_b("flush_done", done, 1'b0);
            end else begin
                chk_b("done_pulse", done, 1'b1);
                chk_b("done_busy", busy, 1'b0);
                chk_i("test_correct", test_correct, ec);
            end
            vexp = (c > 0) && (c - 1 < n) && (q[c-1].pass == 1) && (q[c-1].s == 3);
            chk_b("ec_valid", ec_valid, vexp);
            if (vexp) chk_i("epoch_correct", epoch_correct, ec);
            if (disturb && c == 20) begin
                wr_en = 1'b1;
                wr_index = 2'd3;
                wr_values[0] = 1.0;
                wr_values[1] = 1.0;
                wr_expected = 0.0;
                start = 1'b1;
            end
            if (c == abort_at) begin
                #1 rst = 1'b1;
                #1 chk_zero("abort");
                ws_en = 1'b0;
                return;
            end
        end
        ws_en = 1'b0;
    endtask

    real lab_choice [4];

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_index = '0; wr_values[0] = 0.0; wr_values[1] = 0.0;
        wr_expected = 0.0; start = 1'b0;
        s_wr_en = 1'b0; s_wr_index = '0; s_wr_values[0] = 0.0; s_wr_values[1] = 0.0;
        s_wr_expected = 0.0; s_start = 1'b0;
        lab_choice[0] = 0.0; lab_choice[1] = 0.5;
        lab_choice[2] = 1.0; lab_choice[3] = 0.3;
        #1 chk_zero("reset");
        chk_b("s_reset_busy", s_busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single-sample, single-epoch instance; write and start together.
        @(negedge clk);
        s_wr_en = 1'b1; s_wr_index = 1'b0;
        s_wr_values[0] = 1.0; s_wr_values[1] = 1.0; s_wr_expected = 1.0;
        s_start = 1'b1;
        @(negedge clk);
        s_wr_en = 1'b0; s_start = 1'b0;
        chk_b("s_train0", s_training, 1'b1);
        chk_b("s_busy0", s_busy, 1'b1);
        chk_r("s_v0", s_values[0], 1.0);
        @(negedge clk);
        chk_b("s_eval_train", s_training, 1'b0);
        chk_b("s_eval_ecv", s_ec_valid, 1'b0);
        @(negedge clk);
        chk_b("s_test_ecv", s_ec_valid, 1'b1);
        chk_i("s_test_ec", s_epoch_correct, 1);
        chk_b("s_test_train", s_training, 1'b0);
        @(negedge clk);
        chk_b("s_flush_busy", s_busy, 1'b1);
        chk_b("s_flush_done", s_done, 1'b0);
        @(negedge clk);
        chk_b("s_done", s_done, 1'b1);
        chk_b("s_done_busy", s_busy, 1'b0);
        chk_i("s_tc", s_test_correct, 1);

        load(0, 0.0, 0.0, 0.0);
        load(1, 0.0, 1.0, 0.0);
        load(2, 1.0, 0.0, 0.0);
        load(3, 1.0, 1.0, 1.0);

        do_run(0, 1'b1, -1);
        do_run(1, 1'b0, -1);
        do_run(2, 1'b0, -1);
        do_run(0, 1'b0, 45);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_b("post_rst_ecv", ec_valid, 1'b0);
        chk_b("post_rst_busy", busy, 1'b0);
        do_run(0, 1'b0, -1);

        for (int r = 0; r < 2; r++) begin
            for (int s = 1; s < 4; s++)
                load(s, real'($urandom_range(0, 1)), real'($urandom_range(0, 1)),
                     lab_choice[$urandom_range(0, 3)]);
            ws_en = 1'b1;
            ws_idx = 0;
            ws_a = real'($urandom_range(0, 1));
            ws_b = real'($urandom_range(0, 1));
            ws_l = lab_choice[$urandom_range(0, 3)];
            do_run(r, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
